// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Definitions shared by the multi-cycle control FSM, the datapath and the bench:
//   - 4-bit state encodings (as seen on state_out)
//   - opcode values and the instruction classes the decoder maps them onto
//   - ALUOp, ALUSrcB and PCSource mux encodings
//   - decode_op(): classifies an opcode into an op_class_e

package mc_ctrl_pkg;

  // FSM state encodings
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EX_ALU  = 4'd3;
  localparam logic [3:0] S_WB_ALU  = 4'd4;
  localparam logic [3:0] S_EX_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_WB_MEM  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_EX_BR   = 4'd9;
  localparam logic [3:0] S_EX_JMP  = 4'd10;
  localparam logic [3:0] S_IRQ     = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;
  localparam logic [3:0] S_FAULT   = 4'd13;

  // Opcode values (low four bits; wider opcodes must have zero upper bits)
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_VECTOR = 2'b11;

  typedef enum logic [2:0] {
    OPC_ALU,
    OPC_LOAD,
    OPC_STORE,
    OPC_BEQ,
    OPC_JMP,
    OPC_HALT,
    OPC_ILLEGAL
  } op_class_e;

  // hi_zero tells whether the opcode bits above bit 3 are all zero; any
  // nonzero upper bit makes the instruction illegal.
  function automatic op_class_e decode_op(input logic [3:0] op_lo,
                                          input logic       hi_zero);
    op_class_e cls;
    cls = OPC_ILLEGAL;
    if (hi_zero) begin
      case (op_lo)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: cls = OPC_ALU;
        OP_LOAD:  cls = OPC_LOAD;
        OP_STORE: cls = OPC_STORE;
        OP_BEQ:   cls = OPC_BEQ;
        OP_JMP:   cls = OPC_JMP;
        OP_HALT:  cls = OPC_HALT;
        default:  cls = OPC_ILLEGAL;
      endcase
    end
    decode_op = cls;
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// mc_perf_counters
// Free-running performance counters for the control FSM. Both wrap silently.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   active         FSM is in a counted (non IDLE/HALT/FAULT) state this cycle
//   retire         an instruction retires this cycle
//   cycle_count    number of active cycles
//   instret_count  number of retired instructions

module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (active) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_count <= '0;
    end else if (retire) begin
      instret_count <= instret_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multi-cycle processor control unit with a variable-latency memory handshake
// (timeout to FAULT), illegal-opcode fault, single-level interrupt entry and
// performance counters. All datapath controls are combinational from state,
// with mem_ready/opcode qualifying the states that depend on them.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 leave IDLE
//   opcode                IR opcode field
//   zero_flag             ALU zero (the datapath gates PCWriteCond with it)
//   mem_ready             memory completes the current access this cycle
//   irq                   level interrupt request, sampled at retire
//   PCWrite..EPCWrite     1-bit datapath enables/selects
//   ALUSrcB/ALUOp/PCSource  2-bit mux selects
//   irq_ack               interrupt accepted (IRQ state)
//   fault                 sticky fault flag (FAULT state)
//   cycle_count, instret_count  performance counters
//   state_out             current state for debug

module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int IRQ_EN      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                mem_ready,
  input  logic                irq,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ALUSrcA,
  output logic                MemToReg,
  output logic                IorD,
  output logic                EPCWrite,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                irq_ack,
  output logic                fault,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instret_count,
  output logic [3:0]          state_out
);

  // The wait counter only has to reach MEM_TIMEOUT-1: the cycle that would
  // take it to MEM_TIMEOUT is the one that diverts to FAULT instead.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]        state;
  logic [3:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  op_class_e         op_class;
  logic              mem_wait_state;
  logic              timeout_hit;
  logic              retire;
  logic              active;
  logic [3:0]        after_retire;
  logic              unused_zero_flag;

  // zero_flag is consumed by the datapath's PC-write gate, not by the FSM.
  assign unused_zero_flag = zero_flag;

  assign op_class = decode_op(opcode[3:0], (opcode >> 4) == '0);

  assign mem_wait_state = (state == S_FETCH) || (state == S_MEM_RD) ||
                          (state == S_MEM_WR);

  // A ready in the limit cycle wins, so the timeout needs mem_ready low.
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait_state && !mem_ready &&
                       (wait_cnt == WAIT_LAST);

  assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) ||
                  (state == S_EX_BR)  || (state == S_EX_JMP) ||
                  ((state == S_MEM_WR) && mem_ready);

  assign active = (state != S_IDLE) && (state != S_HALT) &&
                  (state != S_FAULT);

  // irq is only looked at in a retiring cycle.
  assign after_retire = ((IRQ_EN != 0) && irq) ? S_IRQ : S_FETCH;

  assign state_out = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Any state change clears the wait counter, which covers every entry into
  // FETCH/MEM_RD/MEM_WR; it only advances while a memory access stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (mem_wait_state && !mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_DECODE: begin
        case (op_class)
          OPC_ALU:             state_next = S_EX_ALU;
          OPC_LOAD, OPC_STORE: state_next = S_EX_ADDR;
          OPC_BEQ:             state_next = S_EX_BR;
          OPC_JMP:             state_next = S_EX_JMP;
          OPC_HALT:            state_next = S_HALT;
          default:             state_next = S_FAULT;
        endcase
      end
      S_EX_ALU:  state_next = S_WB_ALU;
      S_WB_ALU:  state_next = after_retire;
      S_EX_ADDR: state_next = (op_class == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)        state_next = S_WB_MEM;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_WB_MEM:  state_next = after_retire;
      S_MEM_WR: begin
        if (mem_ready)        state_next = after_retire;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_EX_BR:   state_next = after_retire;
      S_EX_JMP:  state_next = after_retire;
      S_IRQ:     state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      S_FAULT:   state_next = S_FAULT;
      // Unused encodings can only come from an upset; park in FAULT.
      default:   state_next = S_FAULT;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    MemToReg    = 1'b0;
    IorD        = 1'b0;
    EPCWrite    = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    irq_ack     = 1'b0;
    fault       = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC update only in the cycle the fetch actually completes.
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BRANCH;
      end
      S_EX_ALU: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
      end
      S_EX_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EX_BR: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_EX_JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_IRQ: begin
        irq_ack  = 1'b1;
        EPCWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = PCSRC_VECTOR;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: ;
    endcase
  end

  mc_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .reset        (reset),
    .active       (active),
    .retire       (retire),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Self-checking bench for mc_control_fsm. Each scenario builds a per-cycle
// program of inputs and expected states; driving a row pushes the expected
// state plus control vector to a scoreboard, popped and compared #1 later.
// A second instance with IRQ_EN=0 shares the inputs for the tie-off check.

module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       start;
    logic       rdy;
    logic [3:0] op;
    logic       irq;
    logic [3:0] st;
  } row_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } exp_t;

  logic        clk, reset, start, zero_flag, mem_ready, irq;
  logic [3:0]  opcode;
  logic        PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite;
  logic        ALUSrcA, MemToReg, IorD, EPCWrite, irq_ack, fault;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] cycle_count, instret_count;
  logic [3:0]  state_out;

  logic        n_PCWrite, n_PCWriteCond, n_IRWrite, n_RegWrite, n_MemRead;
  logic        n_MemWrite, n_ALUSrcA, n_MemToReg, n_IorD, n_EPCWrite;
  logic        n_irq_ack, n_fault;
  logic [1:0]  n_ALUSrcB, n_ALUOp, n_PCSource;
  logic [31:0] n_cycle_count, n_instret_count;
  logic [3:0]  n_state_out;

  logic [17:0] ctrl_vec;
  exp_t        sb[$];
  row_t        prog[$];
  int          checks = 0;
  int          passed = 0;

  assign ctrl_vec = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite,
                     ALUSrcA, MemToReg, IorD, EPCWrite, ALUSrcB, ALUOp, PCSource,
                     irq_ack, fault};

  mc_control_fsm #(.OPCODE_W(4), .MEM_TIMEOUT(4), .CNT_W(32), .IRQ_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .irq(irq),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrcA(ALUSrcA), .MemToReg(MemToReg), .IorD(IorD), .EPCWrite(EPCWrite),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .irq_ack(irq_ack), .fault(fault), .cycle_count(cycle_count),
    .instret_count(instret_count), .state_out(state_out)
  );

  mc_control_fsm #(.OPCODE_W(4), .MEM_TIMEOUT(4), .CNT_W(32), .IRQ_EN(0)) dut_noirq (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .irq(irq),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IRWrite(n_IRWrite),
    .RegWrite(n_RegWrite), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
    .ALUSrcA(n_ALUSrcA), .MemToReg(n_MemToReg), .IorD(n_IorD),
    .EPCWrite(n_EPCWrite), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp),
    .PCSource(n_PCSource), .irq_ack(n_irq_ack), .fault(n_fault),
    .cycle_count(n_cycle_count), .instret_count(n_instret_count),
    .state_out(n_state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected controls per state, written out from the control table with
  // literal encodings so the package constants are checked as well.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic rdy);
    logic pcw, pcwc, irw, rw, mr, mw, asa, m2r, iord, epc, ack, flt;
    logic [1:0] bsrc, aop, pcs;
    {pcw, pcwc, irw, rw, mr, mw, asa, m2r, iord, epc, ack, flt} = '0;
    bsrc = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      S_FETCH:   begin mr = 1; bsrc = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
      S_DECODE:  bsrc = 2'b11;
      S_EX_ALU:  begin asa = 1; aop = 2'b10; end
      S_WB_ALU:  rw = 1;
      S_EX_ADDR: begin asa = 1; bsrc = 2'b10; end
      S_MEM_RD:  begin iord = 1; mr = 1; end
      S_WB_MEM:  begin rw = 1; m2r = 1; end
      S_MEM_WR:  begin iord = 1; mw = 1; end
      S_EX_BR:   begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      S_EX_JMP:  begin pcw = 1; pcs = 2'b10; end
      S_IRQ:     begin ack = 1; epc = 1; pcw = 1; pcs = 2'b11; end
      S_FAULT:   flt = 1;
      default:   ;
    endcase
    exp_ctrl = {pcw, pcwc, irw, rw, mr, mw, asa, m2r, iord, epc, bsrc, aop, pcs, ack, flt};
  endfunction

  function automatic row_t mk(input logic st_in, input logic rdy, input logic [3:0] op,
                              input logic irq_in, input logic [3:0] st);
    row_t r;
    r.start = st_in; r.rdy = rdy; r.op = op; r.irq = irq_in; r.st = st;
    mk = r;
  endfunction

  task automatic applyStimulus(input row_t r);
    exp_t e;
    @(negedge clk);
    start     = r.start;
    mem_ready = r.rdy;
    opcode    = r.op;
    irq       = r.irq;
    e.st   = r.st;
    e.ctrl = exp_ctrl(r.st, r.rdy);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; irq = 1'b0;
    opcode = OP_ADD; zero_flag = 1'b0;
    sb.delete();
    prog.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1; irq = 1'b1;
    e.st = S_IDLE; e.ctrl = '0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (state_out !== e.st || ctrl_vec !== e.ctrl || cycle_count !== 0 || instret_count !== 0) begin
      $display("[TB] FAIL reset: state=%0d ctrl=%b cyc=%0d ret=%0d, expected state=%0d ctrl=%b cyc=0 ret=0",
               state_out, ctrl_vec, cycle_count, instret_count, e.st, e.ctrl);
    end else passed++;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; irq = 1'b0;
  endtask

  task automatic test_add_halt();
    exp_t e;
    int   rw_cycles;
    do_reset();
    prog.push_back(mk(1, 1, OP_ADD,  0, S_IDLE));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_FETCH));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_DECODE));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_EX_ALU));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_WB_ALU));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_DECODE));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_HALT));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_HALT));
    rw_cycles = 0;
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      rw_cycles += int'(RegWrite);
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL add_halt row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (rw_cycles !== 1 || instret_count !== 1 || cycle_count !== 6) begin
      $display("[TB] FAIL add_halt counts: regwrite=%0d ret=%0d cyc=%0d, expected 1/1/6",
               rw_cycles, instret_count, cycle_count);
    end else passed++;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (cycle_count !== 6 || state_out !== S_HALT) begin
      $display("[TB] FAIL halt_frozen: cyc=%0d state=%0d, expected cyc=6 state=%0d",
               cycle_count, state_out, S_HALT);
    end else passed++;
  endtask

  task automatic test_load_wait();
    exp_t e;
    do_reset();
    prog.push_back(mk(1, 0, OP_LOAD, 0, S_IDLE));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_FETCH));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_FETCH));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_DECODE));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_EX_ADDR));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_MEM_RD));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_MEM_RD));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_MEM_RD));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_WB_MEM));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_DECODE));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_HALT));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL load_wait row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (instret_count !== 1 || cycle_count !== 12) begin
      $display("[TB] FAIL load_wait counts: ret=%0d cyc=%0d, expected 1/12",
               instret_count, cycle_count);
    end else passed++;
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    prog.push_back(mk(1, 1, OP_STORE, 0, S_IDLE));
    prog.push_back(mk(0, 1, OP_STORE, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_STORE, 0, S_DECODE));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_EX_ADDR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_FAULT));
    prog.push_back(mk(0, 1, OP_STORE, 0, S_FAULT));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL timeout row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (fault !== 1'b1 || instret_count !== 0 || cycle_count !== 7) begin
      $display("[TB] FAIL timeout counts: fault=%0b ret=%0d cyc=%0d, expected 1/0/7",
               fault, instret_count, cycle_count);
    end else passed++;
    do_reset();
    #1;
    checks++;
    if (fault !== 1'b0 || state_out !== S_IDLE) begin
      $display("[TB] FAIL fault_clear: fault=%0b state=%0d, expected fault=0 state=%0d",
               fault, state_out, S_IDLE);
    end else passed++;
  endtask

  task automatic test_timeout_boundary();
    exp_t e;
    do_reset();
    prog.push_back(mk(1, 1, OP_STORE, 0, S_IDLE));
    prog.push_back(mk(0, 1, OP_STORE, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_STORE, 0, S_DECODE));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_EX_ADDR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 0, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 1, OP_STORE, 0, S_MEM_WR));
    prog.push_back(mk(0, 1, OP_HALT,  0, S_FETCH));
    prog.push_back(mk(0, 1, OP_HALT,  0, S_DECODE));
    prog.push_back(mk(0, 1, OP_HALT,  0, S_HALT));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL timeout_edge row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (instret_count !== 1 || fault !== 1'b0) begin
      $display("[TB] FAIL timeout_edge counts: ret=%0d fault=%0b, expected 1/0",
               instret_count, fault);
    end else passed++;
  endtask

  task automatic test_illegal();
    exp_t e;
    do_reset();
    prog.push_back(mk(1, 1, 4'hF, 0, S_IDLE));
    prog.push_back(mk(0, 1, 4'hF, 0, S_FETCH));
    prog.push_back(mk(0, 1, 4'hF, 0, S_DECODE));
    prog.push_back(mk(0, 1, 4'hF, 0, S_FAULT));
    prog.push_back(mk(0, 1, 4'hF, 1, S_FAULT));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL illegal row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (instret_count !== 0 || cycle_count !== 2) begin
      $display("[TB] FAIL illegal counts: ret=%0d cyc=%0d, expected 0/2",
               instret_count, cycle_count);
    end else passed++;
  endtask

  task automatic test_irq();
    exp_t e;
    do_reset();
    prog.push_back(mk(1, 1, OP_ADD,  0, S_IDLE));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_FETCH));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_DECODE));
    prog.push_back(mk(0, 1, OP_ADD,  1, S_EX_ALU));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_WB_ALU));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_FETCH));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_DECODE));
    prog.push_back(mk(0, 1, OP_ADD,  1, S_EX_ALU));
    prog.push_back(mk(0, 1, OP_ADD,  1, S_WB_ALU));
    prog.push_back(mk(0, 1, OP_ADD,  0, S_IRQ));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_DECODE));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_HALT));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL irq row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
      if (prog[i].st == S_IRQ) begin
        checks++;
        if (n_state_out !== S_FETCH || n_irq_ack !== 1'b0) begin
          $display("[TB] FAIL irq_disabled: state=%0d ack=%0b, expected state=%0d ack=0",
                   n_state_out, n_irq_ack, S_FETCH);
        end else passed++;
      end
    end
    checks++;
    if (instret_count !== 2) begin
      $display("[TB] FAIL irq counts: ret=%0d, expected 2", instret_count);
    end else passed++;
  endtask

  task automatic test_branch_jump();
    exp_t e;
    do_reset();
    zero_flag = 1'b1;
    prog.push_back(mk(1, 1, OP_BEQ,  0, S_IDLE));
    prog.push_back(mk(0, 1, OP_BEQ,  0, S_FETCH));
    prog.push_back(mk(0, 1, OP_BEQ,  0, S_DECODE));
    prog.push_back(mk(0, 1, OP_BEQ,  0, S_EX_BR));
    prog.push_back(mk(0, 1, OP_JMP,  0, S_FETCH));
    prog.push_back(mk(0, 1, OP_JMP,  0, S_DECODE));
    prog.push_back(mk(0, 1, OP_JMP,  0, S_EX_JMP));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_DECODE));
    prog.push_back(mk(0, 1, OP_HALT, 0, S_HALT));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL branch_jump row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (instret_count !== 2 || cycle_count !== 8) begin
      $display("[TB] FAIL branch_jump counts: ret=%0d cyc=%0d, expected 2/8",
               instret_count, cycle_count);
    end else passed++;
    zero_flag = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    do_reset();
    prog.push_back(mk(1, 1, OP_LOAD, 0, S_IDLE));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_FETCH));
    prog.push_back(mk(0, 1, OP_LOAD, 0, S_DECODE));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_EX_ADDR));
    prog.push_back(mk(0, 0, OP_LOAD, 0, S_MEM_RD));
    for (int i = 0; i < prog.size(); i++) begin
      applyStimulus(prog[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (state_out !== e.st || ctrl_vec !== e.ctrl) begin
        $display("[TB] FAIL reset_mid row %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state_out, ctrl_vec, e.st, e.ctrl);
      end else passed++;
    end
    checks++;
    if (cycle_count !== 3) begin
      $display("[TB] FAIL reset_mid precount: cyc=%0d, expected 3", cycle_count);
    end else passed++;
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_out !== S_IDLE || ctrl_vec !== 18'd0 || cycle_count !== 0 || instret_count !== 0) begin
      $display("[TB] FAIL reset_mid abort: state=%0d ctrl=%b cyc=%0d ret=%0d, expected state=%0d ctrl=0 cyc=0 ret=0",
               state_out, ctrl_vec, cycle_count, instret_count, S_IDLE);
    end else passed++;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (state_out !== S_IDLE || instret_count !== 0) begin
      $display("[TB] FAIL reset_mid after: state=%0d ret=%0d, expected state=%0d ret=0",
               state_out, instret_count, S_IDLE);
    end else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; irq = 1'b0;
    opcode = OP_ADD; zero_flag = 1'b0;
    $display("[TB] start");
    test_reset();
    test_add_halt();
    test_load_wait();
    test_timeout();
    test_timeout_boundary();
    test_illegal();
    test_irq();
    test_branch_jump();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
